// File: rtl/vdg_address_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vdg_address_generator                                                      |
// | Display-memory address, alpha row counter and RP strobe for all 6847 modes.|
// | Optional macro VDG_BASE_ADDR_EN adds a base_addr frame-offset input.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vdg_address_generator #(
  parameter int ADDR_WIDTH   = 13,
  parameter int ROW_WIDTH    = 4,
  parameter int ALPHA_REPEAT = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fsn,
  input  logic                  hsn,
  input  logic                  vactive,
  input  logic                  preload,
  input  logic                  ang,
  input  logic [2:0]            gm,
`ifdef VDG_BASE_ADDR_EN
  input  logic [ADDR_WIDTH-1:0] base_addr,
`endif
  output logic [ADDR_WIDTH-1:0] da,
  output logic [ROW_WIDTH-1:0]  alpha_row,
  output logic                  rp,
  output logic [5:0]            line_bytes
);

  localparam logic [ROW_WIDTH-1:0] c_alphaLast = ROW_WIDTH'(ALPHA_REPEAT - 1);
  localparam logic [5:0]           c_bpr16     = 6'd16;
  localparam logic [5:0]           c_bpr32     = 6'd32;

  logic [ADDR_WIDTH-1:0] r_da;
  logic [ADDR_WIDTH-1:0] r_lineStart;
  logic [ROW_WIDTH-1:0]  r_alphaRow;
  logic                  r_rp;
  logic [5:0]            r_lineBytes;
  logic                  r_hsnD;
  logic                  r_ang;
  logic [2:0]            r_gm;

  logic [5:0]            w_bpr;
  logic [ROW_WIDTH-1:0]  w_repLast;
  logic                  w_lineEnd;
  logic                  w_fetch;
  logic [ADDR_WIDTH-1:0] w_nextStart;
  logic [ADDR_WIDTH-1:0] w_frameBase;

`ifdef VDG_BASE_ADDR_EN
  assign w_frameBase = base_addr;
`else
  assign w_frameBase = '0;
`endif

  // Decode uses the latched mode so a mid-line mode change cannot alter the current line.
  always_comb begin
    w_bpr     = c_bpr32;
    w_repLast = c_alphaLast;
    if (r_ang) begin
      case (r_gm)
        3'd0, 3'd1: begin w_bpr = c_bpr16; w_repLast = ROW_WIDTH'(2); end
        3'd2:       begin w_bpr = c_bpr32; w_repLast = ROW_WIDTH'(2); end
        3'd3:       begin w_bpr = c_bpr16; w_repLast = ROW_WIDTH'(1); end
        3'd4:       begin w_bpr = c_bpr32; w_repLast = ROW_WIDTH'(1); end
        3'd5:       begin w_bpr = c_bpr16; w_repLast = '0;            end
        default:    begin w_bpr = c_bpr32; w_repLast = '0;            end
      endcase
    end
  end

  assign w_lineEnd   = r_hsnD & ~hsn & vactive;
  assign w_fetch     = preload & vactive & ~w_lineEnd & (r_lineBytes < w_bpr);
  assign w_nextStart = r_lineStart + ADDR_WIDTH'(w_bpr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_da        <= '0;
      r_lineStart <= '0;
      r_alphaRow  <= '0;
      r_rp        <= 1'b0;
      r_lineBytes <= '0;
      r_hsnD      <= 1'b1;
      r_ang       <= 1'b0;
      r_gm        <= 3'd0;
    end else begin
      r_hsnD <= hsn;
      r_rp   <= 1'b0;
      if (!fsn || w_lineEnd) begin
        r_ang <= ang;
        r_gm  <= gm;
      end
      if (!fsn) begin
        r_da        <= w_frameBase;
        r_lineStart <= w_frameBase;
        r_alphaRow  <= '0;
        r_lineBytes <= '0;
      end else if (w_lineEnd) begin
        r_lineBytes <= '0;
        if (r_alphaRow == w_repLast) begin
          r_alphaRow  <= '0;
          r_lineStart <= w_nextStart;
          r_da        <= w_nextStart;
          r_rp        <= 1'b1;
        end else begin
          r_alphaRow <= r_alphaRow + 1'b1;
          r_da       <= r_lineStart;
        end
      end else if (w_fetch) begin
        r_da        <= r_da + 1'b1;
        r_lineBytes <= r_lineBytes + 1'b1;
      end
    end
  end

  assign da         = r_da;
  assign alpha_row  = r_alphaRow;
  assign rp         = r_rp;
  assign line_bytes = r_lineBytes;

endmodule
`default_nettype wire

// File: tb/tb_vdg_address_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vdg_address_generator                                                   |
// | Self-checking bench: cycle model plus hand-computed literal expectations.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vdg_address_generator;

  localparam int AW = 13;
  localparam int RW = 4;
  localparam int AREP = 12;
  localparam int MODV = 1 << AW;

  logic clk = 1'b0;
  logic resetn, fsn, hsn, vactive, preload, ang;
  logic [2:0] gm;
  logic [AW-1:0] baseAddr = '0;
  logic [AW-1:0] da;
  logic [RW-1:0] alpha_row;
  logic rp;
  logic [5:0] line_bytes;

  int tests = 0;
  int fails = 0;
  bit cmpEn = 1'b0;

  vdg_address_generator #(.ADDR_WIDTH(AW), .ROW_WIDTH(RW), .ALPHA_REPEAT(AREP)) dut (
    .clk(clk), .resetn(resetn), .fsn(fsn), .hsn(hsn), .vactive(vactive),
    .preload(preload), .ang(ang), .gm(gm),
`ifdef VDG_BASE_ADDR_EN
    .base_addr(baseAddr),
`endif
    .da(da), .alpha_row(alpha_row), .rp(rp), .line_bytes(line_bytes)
  );

  always #5 clk = ~clk;

  // Mode table straight from the mode list: bytes per row and rows per group.
  function automatic int bprOf(input logic a, input logic [2:0] g);
    if (!a) return 32;
    return (g == 3'd0 || g == 3'd1 || g == 3'd3 || g == 3'd5) ? 16 : 32;
  endfunction
  function automatic int repOf(input logic a, input logic [2:0] g);
    if (!a) return AREP;
    if (g <= 3'd2) return 3;
    if (g <= 3'd4) return 2;
    return 1;
  endfunction

  // Reference state, in plain integers.
  int mDa = 0, mStart = 0, mRow = 0, mBytes = 0;
  bit mRp = 0, mHsnPrev = 1, mAng = 0;
  logic [2:0] mGm = 3'd0;

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      mDa = 0; mStart = 0; mRow = 0; mBytes = 0; mRp = 0; mHsnPrev = 1; mAng = 0; mGm = 3'd0;
    end else begin
      int base, bpr, rep;
      bit endOfLine;
`ifdef VDG_BASE_ADDR_EN
      base = int'(baseAddr);
`else
      base = 0;
`endif
      bpr = bprOf(mAng, mGm);
      rep = repOf(mAng, mGm);
      endOfLine = mHsnPrev && !hsn && vactive;
      mRp = 0;
      if (!fsn) begin
        mDa = base; mStart = base; mRow = 0; mBytes = 0;
        mAng = ang; mGm = gm;
      end else if (endOfLine) begin
        if (mRow == rep - 1) begin
          mRow = 0; mStart = (mStart + bpr) % MODV; mDa = mStart; mRp = 1;
        end else begin
          mRow = mRow + 1; mDa = mStart;
        end
        mBytes = 0;
        mAng = ang; mGm = gm;
      end else if (preload && vactive && mBytes < bpr) begin
        mDa = (mDa + 1) % MODV; mBytes = mBytes + 1;
      end
      mHsnPrev = hsn;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmpEn) begin
      tests++;
      if (int'(da) != mDa || int'(alpha_row) != mRow || rp != mRp || int'(line_bytes) != mBytes) begin
        fails++;
        $display("FAIL model t=%0t: da=%0d/%0d row=%0d/%0d rp=%0d/%0d bytes=%0d/%0d (got/expected)",
                 $time, da, mDa, alpha_row, mRow, rp, mRp, line_bytes, mBytes);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic frameStart();
    fsn = 1'b0; tick();
    fsn = 1'b1; vactive = 1'b1;
  endtask

  int preEndDa, preEndBytes, endDa, endRow;
  bit endRp;

  // One active line: nPre preloads (mode switch at swAt), then an hsn falling edge.
  task automatic doLine(input int nPre, input int swAt, input logic [2:0] swGm, input bit coinc);
    for (int i = 0; i < nPre; i++) begin
      if (i == swAt) gm = swGm;
      preload = 1'b1; tick();
    end
    preload = 1'b0;
    preEndDa = int'(da); preEndBytes = int'(line_bytes);
    preload = coinc; hsn = 1'b0; tick();
    endDa = int'(da); endRp = rp; endRow = int'(alpha_row);
    check("bytes cleared at line end", int'(line_bytes), 0);
    preload = 1'b0; hsn = 1'b1; tick();
  endtask

  initial begin
    resetn = 1'b1; fsn = 1'b1; hsn = 1'b1; vactive = 1'b0; preload = 1'b0; ang = 1'b0; gm = 3'd0;
    #1 resetn = 1'b0;
    #3;
    check("reset da", int'(da), 0);
    check("reset alpha_row", int'(alpha_row), 0);
    check("reset rp", int'(rp), 0);
    check("reset line_bytes", int'(line_bytes), 0);
    tick(); tick();
    resetn = 1'b1;
    cmpEn = 1'b1;

    // Alpha: 12-line repeat group of 32 bytes.
    ang = 1'b0; frameStart();
    for (int l = 0; l < 12; l++) begin
      doLine(32, -1, 3'd0, 1'b0);
      if (l == 0) check("alpha line0 preEnd da", preEndDa, 32);
      if (l < 11) begin
        check("alpha reread da", endDa, 0);
        check("alpha row", endRow, l + 1);
        check("alpha no rp", int'(endRp), 0);
      end else begin
        check("alpha row11 da", endDa, 32);
        check("alpha row11 rp", int'(endRp), 1);
        check("alpha row wrap", endRow, 0);
      end
    end

    // GM6: 192 lines of 32 bytes, every line advances.
    ang = 1'b1; gm = 3'd6; frameStart();
    for (int l = 0; l < 192; l++) begin
      doLine(32, -1, 3'd6, 1'b0);
      if (l == 0) begin
        check("gm6 line0 da", endDa, 32);
        check("gm6 line0 rp", int'(endRp), 1);
      end
    end
    check("gm6 final da", int'(da), 6144);

    // GM0: over-fetch saturates at 16 bytes, 3 lines per group.
    gm = 3'd0; frameStart();
    doLine(40, -1, 3'd0, 1'b0);
    check("gm0 bytes saturate", preEndBytes, 16);
    check("gm0 da holds", preEndDa, 16);
    check("gm0 reread", endDa, 0);
    doLine(40, -1, 3'd0, 1'b0);
    doLine(40, -1, 3'd0, 1'b0);
    check("gm0 advance da", endDa, 16);
    check("gm0 advance rp", int'(endRp), 1);

    // GM3 -> GM7 mid-line 1.
    gm = 3'd3; frameStart();
    doLine(32, -1, 3'd3, 1'b0);
    check("gm3 line0 da", endDa, 0);
    doLine(32, 8, 3'd7, 1'b0);
    check("switch keeps bpr16", preEndDa, 16);
    check("switch line1 da", endDa, 16);
    check("switch line1 rp", int'(endRp), 1);
    doLine(32, -1, 3'd7, 1'b0);
    check("gm7 line2 da", endDa, 48);
    check("gm7 line2 rp", int'(endRp), 1);

    // Preload on the line-end cycle is dropped.
    doLine(10, -1, 3'd7, 1'b1);
    check("coincident preload da", endDa, 80);

    // Mid-frame fsn restart.
    for (int i = 0; i < 5; i++) begin preload = 1'b1; tick(); end
    preload = 1'b0;
    check("pre-fsn da", int'(da), 85);
    fsn = 1'b0; tick();
    check("fsn da", int'(da), 0);
    check("fsn alpha_row", int'(alpha_row), 0);
    fsn = 1'b1;

    // Asynchronous reset mid-line.
    doLine(32, -1, 3'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin preload = 1'b1; tick(); end
    preload = 1'b0;
    resetn = 1'b0; #1;
    check("async rst da", int'(da), 0);
    check("async rst row", int'(alpha_row), 0);
    check("async rst bytes", int'(line_bytes), 0);
    tick();
    resetn = 1'b1;
    tick();

`ifdef VDG_BASE_ADDR_EN
    ang = 1'b1; gm = 3'd7; baseAddr = AW'(8190); frameStart();
    check("base da", int'(da), 8190);
    preload = 1'b1; tick(); check("base da+1", int'(da), 8191);
    tick(); check("base wrap", int'(da), 0);
    tick(); check("base after wrap", int'(da), 1);
    preload = 1'b0;
    doLine(29, -1, 3'd7, 1'b0);
    check("base next row start", endDa, 30);
`endif

    tick();
    cmpEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
